// File: rtl/mem_ctrl_pkg.sv
// Shared types for the SRAM sequencing controller: FSM states and command mode encodings.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_COMPUTE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_CLEAR   = 2'b00,
      MODE_LOAD    = 2'b01,
      MODE_COMPUTE = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_t;

endpackage

// File: rtl/addr_delay_line.sv
// Depth-stage shift register of {valid, address}; output appears Depth cycles after input.
// No backpressure: shifts every cycle, flush clears all stages synchronously.
module addr_delay_line #(
   parameter int Addr_Width = 4,
   parameter int Depth      = 3
) (
   input  logic                  clk,
   input  logic                  flush,
   input  logic                  in_vld,
   input  logic [Addr_Width-1:0] in_addr,
   output logic                  out_vld,
   output logic [Addr_Width-1:0] out_addr,
   output logic                  any_vld
);

   logic [Depth-1:0]      vld_q;
   logic [Addr_Width-1:0] addr_q [Depth];

   always_ff @(posedge clk) begin
      if (flush) begin
         vld_q <= '0;
         for (int i = 0; i < Depth; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         vld_q[0]  <= in_vld;
         addr_q[0] <= in_addr;
         for (int i = 1; i < Depth; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   assign out_vld  = vld_q[Depth-1];
   assign out_addr = addr_q[Depth-1];
   assign any_vld  = |vld_q;

endmodule

// File: rtl/mem_seq_controller.sv
// SRAM sequencing controller: CLEAR/LOAD/COMPUTE commands drive per-SRAM strobes and addresses.
// All outputs registered, first strobe one cycle after Start; LOAD stalls on Load_Valid, COMPUTE never stalls.
module mem_seq_controller
   import mem_ctrl_pkg::*;
#(
   parameter int Addr_Width    = 4,
   parameter int Nums_SRAM_In  = 2,
   parameter int Nums_SRAM_Out = 1,
   parameter int Nums_SRAM     = Nums_SRAM_In + Nums_SRAM_Out,
   parameter int Write_Latency = 3
) (
   input  logic                            clk,
   input  logic                            Mem_reset,
   input  logic                            Start,
   input  logic [1:0]                      Mode,
   input  logic [Addr_Width:0]             Length,
   input  logic [Nums_SRAM_In-1:0]         Load_Mask,
   input  logic                            Load_Valid,
   output logic                            Load_Ready,
   output logic                            Busy,
   output logic                            Done,
   output logic [Nums_SRAM-1:0]            Mem_Clear,
   output logic [Nums_SRAM-1:0]            En_Chip_Select,
   output logic [Nums_SRAM-1:0]            En_Read,
   output logic [Nums_SRAM-1:0]            En_Write,
   output logic [Nums_SRAM*Addr_Width-1:0] Addr_Read,
   output logic [Nums_SRAM*Addr_Width-1:0] Addr_Write,
   output logic [Addr_Width:0]             Step_Count
);

   localparam int Ram_Depth = 1 << Addr_Width;
   localparam logic [Addr_Width:0] DEPTH_CNT = (Addr_Width+1)'(Ram_Depth);

   state_t state_q, state_d;
   logic [Addr_Width:0]       step_q, step_d;
   logic [Addr_Width:0]       len_q, len_d;
   logic [Nums_SRAM_In-1:0]   mask_q, mask_d;
   logic [Addr_Width:0]       len_clamped;
   logic                      accept;

   logic                      dl_in_vld, dl_out_vld, dl_any_vld;
   logic [Addr_Width-1:0]     dl_in_addr, dl_out_addr;

   logic                            rdy_d, busy_d, done_d;
   logic [Nums_SRAM-1:0]            clr_d, cs_d, rd_d, wr_d;
   logic [Nums_SRAM*Addr_Width-1:0] ard_d, awr_d;

   assign len_clamped = (Length > DEPTH_CNT) ? DEPTH_CNT : Length;
   assign accept      = Load_Valid & Load_Ready;
   assign Step_Count  = step_q;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      len_d   = len_q;
      mask_d  = mask_q;
      case (state_q)
         ST_IDLE: begin
            if (Start && (mode_t'(Mode) != MODE_RSVD)) begin
               len_d  = len_clamped;
               mask_d = Load_Mask;
               step_d = '0;
               case (mode_t'(Mode))
                  MODE_CLEAR:   state_d = ST_CLEAR;
                  MODE_LOAD:    state_d = (len_clamped == '0) ? ST_DONE : ST_LOAD;
                  MODE_COMPUTE: state_d = (len_clamped == '0) ? ST_DONE : ST_COMPUTE;
                  default:      state_d = ST_IDLE;
               endcase
            end
         end
         ST_CLEAR: begin
            if (step_q == DEPTH_CNT - 1'b1) begin
               state_d = ST_DONE;
               step_d  = '0;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         ST_LOAD: begin
            // DRAIN covers the cycle the last word is written, with Load_Ready already low.
            if (accept) begin
               step_d = step_q + 1'b1;
               if (step_q + 1'b1 == len_q) state_d = ST_DRAIN;
            end
         end
         ST_COMPUTE: begin
            if (step_q == len_q - 1'b1) state_d = ST_DRAIN;
            else                        step_d  = step_q + 1'b1;
         end
         ST_DRAIN: begin
            if (!dl_any_vld) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            step_d  = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reads are issued with the state they belong to; the delay line shifts in lockstep.
   assign dl_in_vld  = (state_d == ST_COMPUTE);
   assign dl_in_addr = step_d[Addr_Width-1:0];

   always_comb begin
      clr_d  = '0;
      cs_d   = '0;
      rd_d   = '0;
      wr_d   = '0;
      ard_d  = '0;
      awr_d  = '0;
      rdy_d  = (state_d == ST_LOAD);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);

      if (state_d == ST_CLEAR) begin
         for (int i = Nums_SRAM_In; i < Nums_SRAM; i++) begin
            cs_d[i]                        = 1'b1;
            clr_d[i]                       = 1'b1;
            wr_d[i]                        = 1'b1;
            awr_d[i*Addr_Width +: Addr_Width] = step_d[Addr_Width-1:0];
         end
      end

      if (state_d == ST_COMPUTE) begin
         for (int i = 0; i < Nums_SRAM_In; i++) begin
            cs_d[i]                        = 1'b1;
            rd_d[i]                        = 1'b1;
            ard_d[i*Addr_Width +: Addr_Width] = step_d[Addr_Width-1:0];
         end
      end

      if (accept) begin
         for (int i = 0; i < Nums_SRAM_In; i++) begin
            if (mask_q[i]) begin
               cs_d[i]                        = 1'b1;
               wr_d[i]                        = 1'b1;
               awr_d[i*Addr_Width +: Addr_Width] = step_q[Addr_Width-1:0];
            end
         end
      end

      if (dl_out_vld) begin
         for (int i = Nums_SRAM_In; i < Nums_SRAM; i++) begin
            cs_d[i]                        = 1'b1;
            wr_d[i]                        = 1'b1;
            awr_d[i*Addr_Width +: Addr_Width] = dl_out_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Mem_reset) begin
         state_q        <= ST_IDLE;
         step_q         <= '0;
         len_q          <= '0;
         mask_q         <= '0;
         Load_Ready     <= 1'b0;
         Busy           <= 1'b0;
         Done           <= 1'b0;
         Mem_Clear      <= '0;
         En_Chip_Select <= '0;
         En_Read        <= '0;
         En_Write       <= '0;
         Addr_Read      <= '0;
         Addr_Write     <= '0;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         len_q          <= len_d;
         mask_q         <= mask_d;
         Load_Ready     <= rdy_d;
         Busy           <= busy_d;
         Done           <= done_d;
         Mem_Clear      <= clr_d;
         En_Chip_Select <= cs_d;
         En_Read        <= rd_d;
         En_Write       <= wr_d;
         Addr_Read      <= ard_d;
         Addr_Write     <= awr_d;
      end
   end

   addr_delay_line #(
      .Addr_Width (Addr_Width),
      .Depth      (Write_Latency)
   ) u_dly (
      .clk      (clk),
      .flush    (Mem_reset),
      .in_vld   (dl_in_vld),
      .in_addr  (dl_in_addr),
      .out_vld  (dl_out_vld),
      .out_addr (dl_out_addr),
      .any_vld  (dl_any_vld)
   );

endmodule
